// File: rtl/cache_tag_lookup_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-way cache tag lookup block.
package cache_tag_lookup_pkg;

  localparam int ADDR_W   = 32;
  localparam int TAG_W    = 24;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 5;
  localparam int WAYS     = 4;
  localparam int SETS     = 1 << INDEX_W;
  localparam int WAY_W    = 2;

  // PLRU bit positions inside the 3-bit per-set state {b2,b1,b0}
  localparam int PLRU_B0 = 0;
  localparam int PLRU_B1 = 1;
  localparam int PLRU_B2 = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOOKUP    = 2'd1,
    ST_RESP      = 2'd2,
    ST_WAIT_FILL = 2'd3
  } state_t;

  function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] w);
    logic [WAYS-1:0] oh;
    oh = '0;
    oh[w] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cache_tag_lookup_if.sv
// Request/response/fill bundle between the cache FSM (master) and the tag lookup block (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid-side payload must stay stable until that edge. fill_done is a 1-cycle pulse.
interface cache_tag_lookup_if;
  import cache_tag_lookup_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [WAY_W-1:0]  resp_way;
  logic [TAG_W-1:0]  resp_vtag;
  logic              resp_vvalid;
  logic              resp_vdirty;
  logic              fill_done;

  modport master (
    output req_valid, req_addr, req_wen, resp_ready, fill_done,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_vtag, resp_vvalid, resp_vdirty
  );

  modport slave (
    input  req_valid, req_addr, req_wen, resp_ready, fill_done,
    output req_ready, resp_valid, resp_hit, resp_way, resp_vtag, resp_vvalid, resp_vdirty
  );

endinterface

// File: rtl/cache_plru.sv
// Per-set 3-bit tree pseudo-LRU state for a 4-way cache: victim lookup and access update.
module cache_plru
  import cache_tag_lookup_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic [INDEX_W-1:0] idx,
  input  logic               upd_en,
  input  logic [WAY_W-1:0]   upd_way,
  output logic [WAY_W-1:0]   victim
);

  logic [SETS-1:0][2:0] bits_q;
  logic [2:0]           cur;

  assign cur    = bits_q[idx];
  // b0 picks the pair, then b1 (pair 0/1) or b2 (pair 2/3) picks the way
  assign victim = cur[PLRU_B0] ? {1'b1, cur[PLRU_B2]} : {1'b0, cur[PLRU_B1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bits_q <= '0;
    end else if (upd_en) begin
      if (!upd_way[1]) begin
        bits_q[idx][PLRU_B0] <= 1'b1;
        bits_q[idx][PLRU_B1] <= ~upd_way[0];
      end else begin
        bits_q[idx][PLRU_B0] <= 1'b0;
        bits_q[idx][PLRU_B2] <= ~upd_way[0];
      end
    end
  end

endmodule

// File: rtl/cache_tag_lookup.sv
// 4-way hit/miss and replacement controller behind the per-way tag arrays.
// Optional macro CACHE_DIRTY_EN keeps per-line dirty bits; without it resp_vdirty is 0.
module cache_tag_lookup
  import cache_tag_lookup_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  cache_tag_lookup_if.slave     bus,
  output logic [INDEX_W-1:0]    tag_raddr,
  input  logic [WAYS*TAG_W-1:0] tag_rdata,
  output logic [INDEX_W-1:0]    tag_waddr,
  output logic [WAYS-1:0]       tag_wen,
  output logic [TAG_W-1:0]      tag_wdata,
  output logic [1:0]            state_dbg
);

  state_t                     state_q;
  logic [TAG_W-1:0]           tag_q;
  logic [INDEX_W-1:0]         idx_q;
  logic                       wen_q;
  logic [WAYS-1:0][SETS-1:0]  valid_q;

  logic                       resp_valid_q;
  logic                       hit_q;
  logic [WAY_W-1:0]           way_q;
  logic [TAG_W-1:0]           vtag_q;
  logic                       vvalid_q;
  logic                       vdirty_q;

  logic [TAG_W-1:0]           rd_tag [WAYS];
  logic [WAYS-1:0]            line_valid;
  logic [WAYS-1:0]            line_dirty;
  logic [WAYS-1:0]            match;
  logic                       hit_any;
  logic [WAY_W-1:0]           hit_way;
  logic [WAY_W-1:0]           inv_way;
  logic [WAY_W-1:0]           plru_victim;
  logic [WAY_W-1:0]           sel_way;
  logic                       hit_upd;
  logic                       fill_upd;
  logic                       unused_offset;

  assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_tag[w]     = tag_rdata[w*TAG_W +: TAG_W];
      line_valid[w] = valid_q[w][idx_q];
      match[w]      = line_valid[w] && (rd_tag[w] == tag_q);
    end
  end

  // Descending scans leave the lowest matching / lowest invalid way selected
  always_comb begin
    hit_any = |match;
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w])       hit_way = WAY_W'(w);
      if (!line_valid[w]) inv_way = WAY_W'(w);
    end
    sel_way = hit_any ? hit_way : ((&line_valid) ? plru_victim : inv_way);
  end

  assign hit_upd  = (state_q == ST_RESP) && bus.resp_ready && hit_q;
  assign fill_upd = (state_q == ST_WAIT_FILL) && bus.fill_done;

  cache_plru u_plru (
    .clk     (clk),
    .resetn  (resetn),
    .idx     (idx_q),
    .upd_en  (hit_upd || fill_upd),
    .upd_way (way_q),
    .victim  (plru_victim)
  );

`ifdef CACHE_DIRTY_EN
  logic [WAYS-1:0][SETS-1:0] dirty_q;

  always_comb begin
    for (int w = 0; w < WAYS; w++) line_dirty[w] = dirty_q[w][idx_q];
  end

  // Store hits set the bit; a fill overwrites it with the store/load flavour of the request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dirty_q <= '0;
    end else if (hit_upd && wen_q) begin
      dirty_q[way_q][idx_q] <= 1'b1;
    end else if (fill_upd) begin
      dirty_q[way_q][idx_q] <= wen_q;
    end
  end
`else
  assign line_dirty = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      wen_q        <= 1'b0;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      vtag_q       <= '0;
      vvalid_q     <= 1'b0;
      vdirty_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            tag_q   <= bus.req_addr[ADDR_W-1 -: TAG_W];
            idx_q   <= bus.req_addr[OFFSET_W +: INDEX_W];
            wen_q   <= bus.req_wen;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          resp_valid_q <= 1'b1;
          hit_q        <= hit_any;
          way_q        <= sel_way;
          vtag_q       <= rd_tag[sel_way];
          vvalid_q     <= line_valid[sel_way];
          vdirty_q     <= line_dirty[sel_way];
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= hit_q ? ST_IDLE : ST_WAIT_FILL;
          end
        end
        ST_WAIT_FILL: begin
          if (bus.fill_done) begin
            valid_q[way_q][idx_q] <= 1'b1;
            state_q               <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = hit_q;
  assign bus.resp_way    = way_q;
  assign bus.resp_vtag   = vtag_q;
  assign bus.resp_vvalid = vvalid_q;
  assign bus.resp_vdirty = vdirty_q;

  assign tag_raddr = idx_q;
  assign tag_waddr = idx_q;
  assign tag_wdata = tag_q;
  assign tag_wen   = fill_upd ? way_onehot(way_q) : '0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Bench for cache_tag_lookup: vector table through a scoreboard queue, plus a mid-fill reset sequence.
module tb_cache_tag_lookup;
  import cache_tag_lookup_pkg::*;

  logic                  clk;
  logic                  resetn;
  logic [INDEX_W-1:0]    tag_raddr;
  logic [WAYS*TAG_W-1:0] tag_rdata;
  logic [INDEX_W-1:0]    tag_waddr;
  logic [WAYS-1:0]       tag_wen;
  logic [TAG_W-1:0]      tag_wdata;
  logic [1:0]            state_dbg;

  cache_tag_lookup_if bus();

  cache_tag_lookup dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .tag_raddr (tag_raddr),
    .tag_rdata (tag_rdata),
    .tag_waddr (tag_waddr),
    .tag_wen   (tag_wen),
    .tag_wdata (tag_wdata),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tag arrays: asynchronous read, synchronous write, never cleared by reset
  logic [TAG_W-1:0] tarr [WAYS][SETS];
  assign tag_rdata = {tarr[3][tag_raddr], tarr[2][tag_raddr], tarr[1][tag_raddr], tarr[0][tag_raddr]};
  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++)
      if (tag_wen[w]) tarr[w][tag_waddr] <= tag_wdata;
  end

`ifdef CACHE_DIRTY_EN
  localparam logic DIRTY_EXP = 1'b1;
`else
  localparam logic DIRTY_EXP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic        hit;
    logic [1:0]  way;
    logic [23:0] vtag;
    logic        vvalid;
    logic        vdirty;
    int          hold;
    bit          stray;
    bit          fill;
  } vec_t;

  vec_t        vecs [17];
  logic [28:0] exp_q [$];
  int          n_vec;
  int          n_err;
  int          n_checks;

  function automatic vec_t mk(input logic [31:0] addr, input logic wen, input logic hit,
                              input logic [1:0] way, input logic [23:0] vtag, input logic vvalid,
                              input logic vdirty, input int hold, input bit stray, input bit fill);
    vec_t v;
    v.addr = addr; v.wen = wen; v.hit = hit; v.way = way; v.vtag = vtag;
    v.vvalid = vvalid; v.vdirty = vdirty; v.hold = hold; v.stray = stray; v.fill = fill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [28:0] resp_now();
    return {bus.resp_hit, bus.resp_way, bus.resp_vtag, bus.resp_vvalid, bus.resp_vdirty};
  endfunction

  // driver: called and returns on a falling edge
  task automatic run_vec(input vec_t v);
    logic [28:0] first;
    logic [28:0] exp;
    int          hold;
    int          cyc;
    int          dly;
    exp_q.push_back({v.hit, v.way, v.vtag, v.vvalid, v.vdirty});
    n_vec++;
    bus.req_addr  = v.addr;
    bus.req_wen   = v.wen;
    bus.req_valid = 1'b1;
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_accept", {31'd0, bus.req_ready}, 32'd1);
    // handshake edge, then one lookup cycle, then the response (request cycle = cycle 0)
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("lookup_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("lookup_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("resp_latency", {31'd0, bus.resp_valid}, 32'd1);
    first = resp_now();
    hold = (v.hold >= 0) ? v.hold : int'($urandom_range(0, 2));
    for (int i = 0; i < hold; i++) begin
      if (v.stray && i == 1) begin
        bus.fill_done = 1'b1;
        #1;
        chk("stray_fill_wen", {28'd0, tag_wen}, 32'd0);
      end
      @(negedge clk);
      bus.fill_done = 1'b0;
      chk("hold_stable", {3'd0, resp_now()}, {3'd0, first});
      chk("hold_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    exp = exp_q.pop_front();
    chk("resp_hit", {31'd0, bus.resp_hit}, {31'd0, exp[28]});
    chk("resp_way", {30'd0, bus.resp_way}, {30'd0, exp[27:26]});
    if (!exp[28]) begin
      chk("resp_vtag", {8'd0, bus.resp_vtag}, {8'd0, exp[25:2]});
      chk("resp_vvalid", {31'd0, bus.resp_vvalid}, {31'd0, exp[1]});
      chk("resp_vdirty", {31'd0, bus.resp_vdirty}, {31'd0, exp[0]});
    end
    chk("resp_tag_wen", {28'd0, tag_wen}, 32'd0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_drop", {31'd0, bus.resp_valid}, 32'd0);
    if (v.hit) begin
      chk("hit_to_idle", {31'd0, bus.req_ready}, 32'd1);
      chk("hit_no_wen", {28'd0, tag_wen}, 32'd0);
    end else begin
      chk("miss_wait_state", {30'd0, state_dbg}, 32'd3);
      if (v.fill) begin
        dly = int'($urandom_range(0, 3));
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          chk("wait_no_wen", {28'd0, tag_wen}, 32'd0);
          chk("wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.fill_done = 1'b1;
        #1;
        chk("fill_wen", {28'd0, tag_wen}, {28'd0, 4'(4'b0001 << v.way)});
        chk("fill_waddr", {29'd0, tag_waddr}, {29'd0, v.addr[7:5]});
        chk("fill_wdata", {8'd0, tag_wdata}, {8'd0, v.addr[31:8]});
        @(negedge clk);
        bus.fill_done = 1'b0;
        chk("fill_to_idle", {31'd0, bus.req_ready}, 32'd1);
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_resp_fields"}, {3'd0, resp_now()}, 32'd0);
    chk({tag, "_tag_wen"}, {28'd0, tag_wen}, 32'd0);
    chk({tag, "_tag_raddr"}, {29'd0, tag_raddr}, 32'd0);
    chk({tag, "_tag_waddr"}, {29'd0, tag_waddr}, 32'd0);
    chk({tag, "_tag_wdata"}, {8'd0, tag_wdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_vec = 0; n_err = 0; n_checks = 0;
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) tarr[w][s] = '0;
    // addr, wen, hit, way, vtag, vvalid, vdirty, hold(-1 random), stray, fill
    vecs[0]  = mk(32'h0000_1020, 0, 0, 2'd0, 24'h000000, 0, 0,         -1, 0, 1);
    vecs[1]  = mk(32'h0000_1024, 0, 1, 2'd0, 24'h000000, 0, 0,         -1, 0, 0);
    vecs[2]  = mk(32'h0000_1120, 0, 0, 2'd1, 24'h000000, 0, 0,         -1, 0, 1);
    vecs[3]  = mk(32'h0000_1220, 0, 0, 2'd2, 24'h000000, 0, 0,         -1, 0, 1);
    vecs[4]  = mk(32'h0000_1320, 0, 0, 2'd3, 24'h000000, 0, 0,         -1, 0, 1);
    vecs[5]  = mk(32'h0000_1020, 0, 1, 2'd0, 24'h000000, 0, 0,         -1, 0, 0);
    vecs[6]  = mk(32'h0000_2020, 0, 0, 2'd2, 24'h000012, 1, 0,          5, 1, 1);
    vecs[7]  = mk(32'h0000_1020, 1, 1, 2'd0, 24'h000000, 0, 0,         -1, 0, 0);
    vecs[8]  = mk(32'h0000_1120, 0, 1, 2'd1, 24'h000000, 0, 0,         -1, 0, 0);
    vecs[9]  = mk(32'h0000_1320, 0, 1, 2'd3, 24'h000000, 0, 0,         -1, 0, 0);
    vecs[10] = mk(32'h0000_3020, 0, 0, 2'd0, 24'h000010, 1, DIRTY_EXP, -1, 0, 1);
    vecs[11] = mk(32'h0000_ABE0, 1, 0, 2'd0, 24'h000000, 0, 0,         -1, 0, 1);
    vecs[12] = mk(32'h0000_AB60, 0, 0, 2'd0, 24'h000000, 0, 0,         -1, 0, 1);
    vecs[13] = mk(32'h0000_ABE4, 0, 1, 2'd0, 24'h000000, 0, 0,         -1, 0, 0);
    vecs[14] = mk(32'h0000_5040, 0, 0, 2'd0, 24'h000000, 0, 0,         -1, 0, 0);
    vecs[15] = mk(32'h0000_5040, 0, 0, 2'd0, 24'h000000, 0, 0,         -1, 0, 1);
    vecs[16] = mk(32'h0000_1020, 0, 0, 2'd0, 24'h000030, 0, 0,         -1, 0, 1);

    bus.req_valid = 0; bus.req_addr = '0; bus.req_wen = 0;
    bus.resp_ready = 0; bus.fill_done = 0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_state", {30'd0, state_dbg}, 32'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // vecs[14] left the block waiting for a fill; reset it there
    chk("pre_reset_wait", {30'd0, state_dbg}, 32'd3);
    resetn = 1'b0;
    bus.fill_done = 1'b1;
    #1;
    chk_zero_outputs("midfill_reset");
    @(negedge clk);
    bus.fill_done = 1'b0;
    resetn = 1'b1;
    #1;
    chk("post_reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post_reset_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    bus.fill_done = 1'b1;
    #1;
    chk("idle_stray_fill_wen", {28'd0, tag_wen}, 32'd0);
    @(negedge clk);
    bus.fill_done = 1'b0;
    chk("idle_stray_fill_state", {30'd0, state_dbg}, 32'd0);

    run_vec(vecs[15]);
    run_vec(vecs[16]);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
